instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Upstream feed stage for `processor`. Buffers 38-bit packed instructions in a small FIFO, accepted over a valid/ready handshake. Pops at most one per cycle and drives the processor's `mode`, `F`, `read_addr1`, `read_addr2`, `dest_addr`, `store_addr`, `store_data` from registered outputs. The processor writes its register file on every edge with no enable, so whenever no instruction is issued this block drives a scratch-register NOP.

## Interface
- `DEPTH`, 4: FIFO entries, power of two, ≥2.
- `NOP_REG`, 31: scratch register written by NOPs; software never allocates it.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: `in_instr` holds an instruction.
- `in_ready` out 1: FIFO can accept; transfer occurs on an edge with `in_valid & in_ready`.
- `in_instr` in 38: packed instruction.
  - [37] = mode.
  - mode=1: [36:32] store_addr, [31:0] store_data.
  - mode=0: [17:15] F, [14:10] read_addr1, [9:5] read_addr2, [4:0] dest_addr; [36:18] ignored.
- `run` in 1: 1 = pop and issue; 0 = hold FIFO, issue NOPs.
- `mode` out 1, `F` out 3, `read_addr1` out 5, `read_addr2` out 5, `dest_addr` out 5, `store_addr` out 5, `store_data` out 32: registered processor controls.
- `issue_valid` out 1: outputs carry a real (non-NOP) instruction this cycle.
- `fifo_count` out $clog2(DEPTH)+1: entries held.
- `issue_count` out 16: real instructions issued since reset, wraps 0xFFFF→0.

## Operation
- FIFO: circular buffer, write/read pointers wrap modulo DEPTH, separate occupancy counter.
- `in_ready = (fifo_count < DEPTH)`. It depends only on the registered count, not on a same-cycle pop.
  - Full FIFO: no push that cycle even if a pop occurs.
- Pop condition per edge: `run & (fifo_count != 0)`.
- Push and pop on the same edge: count unchanged; both pointers advance.
- On pop, the output registers load the decoded entry:
  - mode=1: `mode=1`, `store_addr`/`store_data` from fields; F/read/dest = 0.
  - mode=0: `mode=0`, `F`/`read_addr1`/`read_addr2`/`dest_addr` from fields; `store_addr=0`, `store_data=0`.
  - `issue_valid=1`; `issue_count` += 1 (16-bit wrap).
- No pop: output registers load the NOP.
  - NOP = `mode=0`, `F=0`, `read_addr1=0`, `read_addr2=0`, `dest_addr=NOP_REG`, `store_addr=0`, `store_data=0`.
  - `issue_valid=0`.
- Two states:
  - IDLE (count==0 or run==0): NOPs.
  - ISSUE (count!=0 and run==1): one instruction per cycle.
  - State is derived from registered count and `run`; no separate encoding is required.
- `run` deasserted mid-stream: the instruction already in the output registers completes; the next edge loads a NOP; FIFO contents are preserved.
- No data hazard handling: the processor reads combinationally and writes at the edge, so back-to-back dependent instructions are correct.

## Timing
- Reset (async assert, outputs immediately):
  - FIFO empty, `fifo_count=0`, `in_ready=1`.
  - Outputs = NOP (`dest_addr=NOP_REG`), `issue_valid=0`, `issue_count=0`.
  - FIFO storage contents need not reset.
- Latency into an empty FIFO with run=1:
  - Edge k: push.
  - Edge k+1: pop; outputs valid after k+1.
  - Edge k+2: processor writes the result.
- Throughput: one instruction per cycle sustained. With `in_valid` held and `run=1`, count stays ≤1.
- Reset asserted mid-stream: FIFO contents discarded; the NOP is driven immediately. The first accept is possible on the first edge after deassertion.
- `run` is sampled at the edge only; there is no combinational path from `run` or `in_valid` to any output except via registers. `in_ready` is registered-count based.

## Test plan
- Reset with `in_valid=0` for 5 cycles:
  - Outputs `mode=0`, `dest_addr=31`, `issue_valid=0`, `fifo_count=0`, `in_ready=1`.
  - Processor reg 31 is the only register written.
- run=1, push store {mode=1, addr=3, data=0x0000_00AA} at edge k:
  - After edge k+1: `mode=1`, `store_addr=3`, `store_data=0xAA`, `issue_valid=1`.
  - After k+2: processor reg3=0xAA, `issue_count=1`.
- run=0, push 5 instructions back-to-back:
  - 4 accepted, `fifo_count=4`, `in_ready=0`, 5th held. All outputs remain NOP.
  - Raise run: 4 consecutive issues in push order, then the 5th, then NOPs.
- Store r1=5, store r2=7, then ALU F=add r1,r2→r1 issued back-to-back: reg1=12 two edges after the ALU pop.
- Full FIFO with run=1 and `in_valid=1`:
  - `in_ready` stays 0 on the cycle count==4; count drops to 3; a push is accepted the next edge.
  - No instruction lost or duplicated.
- Assert rst asynchronously with 3 entries queued:
  - Outputs NOP immediately, `fifo_count=0`, `issue_count=0`.
  - After release no stale instruction issues.
- Issue 65 537 instructions: `issue_count` reads 1 (wrap).

Source files
------------

// File: rtl/instr_sequencer_if.sv
// Instruction feed handshake into the sequencer: producer drives valid/instr, sequencer returns ready.
interface instr_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [37:0] in_instr;

    modport master (output in_valid, output in_instr, input in_ready);
    modport slave  (input in_valid, input in_instr, output in_ready);
endinterface

// File: rtl/instr_sequencer.sv
// Buffers packed instructions and issues one per cycle to the processor from registered controls, NOP otherwise.
// Pop-to-output latency is one edge; in_ready drops only when the FIFO holds DEPTH entries.
module instr_sequencer #(
    parameter int DEPTH   = 4,
    parameter int NOP_REG = 31
) (
    input  logic                     clk,
    input  logic                     rst,
    instr_sequencer_if.slave         in_bus,
    input  logic                     run,
    output logic                     mode,
    output logic [2:0]               F,
    output logic [4:0]               read_addr1,
    output logic [4:0]               read_addr2,
    output logic [4:0]               dest_addr,
    output logic [4:0]               store_addr,
    output logic [31:0]              store_data,
    output logic                     issue_valid,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [15:0]              issue_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic        mode;
        logic [2:0]  f;
        logic [4:0]  read_addr1;
        logic [4:0]  read_addr2;
        logic [4:0]  dest_addr;
        logic [4:0]  store_addr;
        logic [31:0] store_data;
    } ctrl_t;

    localparam ctrl_t NOP = '{mode: 1'b0, f: 3'd0, read_addr1: 5'd0, read_addr2: 5'd0,
                              dest_addr: 5'(NOP_REG), store_addr: 5'd0, store_data: 32'd0};

    typedef enum logic {IDLE, ISSUE} state_t;

    logic [37:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [37:0]   head;
    logic          push;
    logic          pop;
    state_t        state;
    ctrl_t         ctrl_d;
    ctrl_t         ctrl_q;

    // Ready looks only at the registered count, so a full FIFO refuses a push even while popping.
    assign in_bus.in_ready = (fifo_count < FULL_CNT);
    assign push            = in_bus.in_valid & in_bus.in_ready;
    assign pop             = (state == ISSUE);

    // State is a pure function of registered occupancy and the sampled run level.
    always_comb begin
        state = IDLE;
        if (run && (fifo_count != '0))
            state = ISSUE;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_bus.in_instr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_comb begin
        head   = mem[rd_ptr];
        ctrl_d = NOP;
        if (state == ISSUE) begin
            ctrl_d = '0;
            if (head[37]) begin
                ctrl_d.mode       = 1'b1;
                ctrl_d.store_addr = head[36:32];
                ctrl_d.store_data = head[31:0];
            end else begin
                ctrl_d.f          = head[17:15];
                ctrl_d.read_addr1 = head[14:10];
                ctrl_d.read_addr2 = head[9:5];
                ctrl_d.dest_addr  = head[4:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q      <= NOP;
            issue_valid <= 1'b0;
            issue_count <= 16'd0;
        end else begin
            ctrl_q      <= ctrl_d;
            issue_valid <= pop;
            if (pop)
                issue_count <= issue_count + 16'd1;
        end
    end

    assign mode       = ctrl_q.mode;
    assign F          = ctrl_q.f;
    assign read_addr1 = ctrl_q.read_addr1;
    assign read_addr2 = ctrl_q.read_addr2;
    assign dest_addr  = ctrl_q.dest_addr;
    assign store_addr = ctrl_q.store_addr;
    assign store_data = ctrl_q.store_data;
endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer with a small register-file model standing in for the processor.
module tb_instr_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        mode;
    logic [2:0]  F;
    logic [4:0]  read_addr1, read_addr2, dest_addr, store_addr;
    logic [31:0] store_data;
    logic        issue_valid;
    logic [2:0]  fifo_count;
    logic [15:0] issue_count;

    instr_sequencer_if bus();

    instr_sequencer #(.DEPTH(4), .NOP_REG(31)) dut (
        .clk(clk), .rst(rst), .in_bus(bus), .run(run),
        .mode(mode), .F(F), .read_addr1(read_addr1), .read_addr2(read_addr2),
        .dest_addr(dest_addr), .store_addr(store_addr), .store_data(store_data),
        .issue_valid(issue_valid), .fifo_count(fifo_count), .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [55:0] sb[$];
    logic [15:0] model_cnt = 16'd0;
    logic [31:0] regs [32];

    localparam logic [55:0] NOP_VEC = {1'b0, 3'd0, 5'd0, 5'd0, 5'd31, 5'd0, 32'd0};
    wire [55:0] out_vec = {mode, F, read_addr1, read_addr2, dest_addr, store_addr, store_data};

    function automatic logic [55:0] expect_of(input logic [37:0] i);
        if (i[37])
            return {1'b1, 3'd0, 5'd0, 5'd0, 5'd0, i[36:32], i[31:0]};
        return {1'b0, i[17:15], i[14:10], i[9:5], i[4:0], 5'd0, 32'd0};
    endfunction

    function automatic logic [37:0] st(input logic [4:0] a, input logic [31:0] d);
        return {1'b1, a, d};
    endfunction

    function automatic logic [37:0] alu(input logic [2:0] f, input logic [4:0] a, input logic [4:0] b,
                                        input logic [4:0] d);
        return {1'b0, 19'd0, f, a, b, d};
    endfunction

    // Processor: combinational read, unconditional write at every edge. F=0 is add.
    always @(posedge clk) begin
        if (mode)
            regs[store_addr] <= store_data;
        else case (F)
            3'd0:    regs[dest_addr] <= regs[read_addr1] + regs[read_addr2];
            3'd1:    regs[dest_addr] <= regs[read_addr1] - regs[read_addr2];
            default: regs[dest_addr] <= regs[read_addr1] ^ regs[read_addr2];
        endcase
    end

    // Accepted pushes enter the scoreboard at the edge; issued outputs are compared just after it.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sb.delete();
            model_cnt = 16'd0;
        end else begin
            if (bus.in_valid && bus.in_ready)
                sb.push_back(expect_of(bus.in_instr));
            #1;
            n_tests++;
            if (issue_valid) begin
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_issue got=%h required=no issue", out_vec);
                end else begin
                    logic [55:0] exp_v;
                    exp_v = sb.pop_front();
                    model_cnt = model_cnt + 16'd1;
                    if (out_vec !== exp_v) begin
                        n_fail++;
                        $display("FAIL sb_issue got=%h required=%h", out_vec, exp_v);
                    end
                end
            end else if (out_vec !== NOP_VEC) begin
                n_fail++;
                $display("FAIL sb_nop got=%h required=%h", out_vec, NOP_VEC);
            end
            n_tests++;
            if (issue_count !== model_cnt) begin
                n_fail++;
                $display("FAIL sb_issue_count got=%0d required=%0d", issue_count, model_cnt);
            end
        end
    end

    task automatic test_reset();
        repeat (5) begin
            @(posedge clk); #1;
            n_tests++;
            if ({mode, dest_addr, issue_valid, fifo_count, bus.in_ready, issue_count} !==
                {1'b0, 5'd31, 1'b0, 3'd0, 1'b1, 16'd0}) begin
                n_fail++;
                $display("FAIL reset_state got=%b_%0d_%b_%0d_%b_%0d required=0_31_0_0_1_0",
                         mode, dest_addr, issue_valid, fifo_count, bus.in_ready, issue_count);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_store_latency();
        run = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_instr = st(5'd3, 32'h0000_00AA);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_tests++;
        if (fifo_count !== 3'd1 || issue_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL store_pushed got=cnt%0d/iv%b required=cnt1/iv0", fifo_count, issue_valid);
        end
        @(posedge clk); #1;
        n_tests++;
        if ({mode, store_addr, store_data, issue_valid} !== {1'b1, 5'd3, 32'hAA, 1'b1}) begin
            n_fail++;
            $display("FAIL store_issue got=m%b a%0d d%h iv%b required=m1 a3 d000000aa iv1",
                     mode, store_addr, store_data, issue_valid);
        end
        @(posedge clk); #1;
        n_tests++;
        if (regs[3] !== 32'hAA || issue_count !== 16'd1) begin
            n_fail++;
            $display("FAIL store_commit got=r3=%h cnt=%0d required=r3=000000aa cnt=1", regs[3], issue_count);
        end
    endtask

    task automatic test_fill_then_run();
        int exp_cnt [5] = '{3, 3, 2, 1, 0};
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = alu(3'(i), 5'(i + 1), 5'(i + 2), 5'(i + 10));
            @(posedge clk); #1;
        end
        n_tests++;
        if (fifo_count !== 3'd4 || bus.in_ready !== 1'b0 || issue_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_hold got=cnt%0d rdy%b iv%b required=cnt4 rdy0 iv0",
                     fifo_count, bus.in_ready, issue_valid);
        end
        run = 1'b1;
        for (int e = 0; e < 6; e++) begin
            @(posedge clk); #1;
            if (e == 1)
                bus.in_valid = 1'b0;
            n_tests++;
            if (e < 5 && (issue_valid !== 1'b1 || fifo_count !== 3'(exp_cnt[e]))) begin
                n_fail++;
                $display("FAIL full_drain edge%0d got=iv%b cnt%0d required=iv1 cnt%0d",
                         e, issue_valid, fifo_count, exp_cnt[e]);
            end else if (e == 5 && issue_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL full_drain_idle got=iv%b required=iv0", issue_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [37:0] prog [3];
        prog[0] = st(5'd1, 32'd5);
        prog[1] = st(5'd2, 32'd7);
        prog[2] = alu(3'd0, 5'd1, 5'd2, 5'd1);
        run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = prog[i];
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        n_tests++;
        if (regs[1] !== 32'd12 || regs[2] !== 32'd7) begin
            n_fail++;
            $display("FAIL dependent_add got=r1=%0d r2=%0d required=r1=12 r2=7", regs[1], regs[2]);
        end
    endtask

    task automatic test_run_pause();
        run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = alu(3'd2, 5'(i), 5'(i + 4), 5'(i + 20));
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        run = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            n_tests++;
            if (issue_valid !== 1'b0 || fifo_count !== 3'd1) begin
                n_fail++;
                $display("FAIL run_pause got=iv%b cnt%0d required=iv0 cnt1", issue_valid, fifo_count);
            end
        end
        run = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (issue_valid !== 1'b1 || fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL run_resume got=iv%b cnt%0d required=iv1 cnt0", issue_valid, fifo_count);
        end
    endtask

    task automatic test_async_reset();
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = st(5'(i + 5), 32'(i + 100));
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        n_tests++;
        if (fifo_count !== 3'd3) begin
            n_fail++;
            $display("FAIL arst_preload got=%0d required=3", fifo_count);
        end
        #3 rst = 1'b1;
        #1;
        n_tests++;
        if (out_vec !== NOP_VEC || issue_valid !== 1'b0 || fifo_count !== 3'd0 ||
            issue_count !== 16'd0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_immediate got=%h iv%b cnt%0d ic%0d rdy%b required=%h iv0 cnt0 ic0 rdy1",
                     out_vec, issue_valid, fifo_count, issue_count, bus.in_ready, NOP_VEC);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            n_tests++;
            if (issue_valid !== 1'b0 || fifo_count !== 3'd0) begin
                n_fail++;
                $display("FAIL arst_stale got=iv%b cnt%0d required=iv0 cnt0", issue_valid, fifo_count);
            end
        end
    endtask

    task automatic test_wrap();
        logic [63:0] r;
        run = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            r = {$urandom, $urandom};
            bus.in_valid = 1'b1;
            bus.in_instr = r[37:0];
            @(posedge clk); #1;
            n_tests++;
            if (fifo_count > 3'd1 || bus.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_occupancy iter%0d got=cnt%0d rdy%b required=cnt<=1 rdy1",
                         i, fifo_count, bus.in_ready);
            end
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (issue_count !== 16'd1 || fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL issue_wrap got=ic%0d cnt%0d required=ic1 cnt0", issue_count, fifo_count);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        test_reset();
        test_store_latency();
        test_fill_then_run();
        test_back_to_back();
        test_run_pause();
        test_async_reset();
        test_wrap();
        repeat (2) @(posedge clk);
        #2;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drained got=%0d pending required=0 pending", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
